// File: rtl/rv32i_pkg.sv
// Purpose: shared encodings for the RV32I multicycle control path (opcodes, ALU codes, states, mux selects).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv32i_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] op_r      = 7'b0110011;
  localparam logic [6:0] op_imm    = 7'b0010011;
  localparam logic [6:0] op_load   = 7'b0000011;
  localparam logic [6:0] op_store  = 7'b0100011;
  localparam logic [6:0] op_branch = 7'b1100011;
  localparam logic [6:0] op_jal    = 7'b1101111;
  localparam logic [6:0] op_jalr   = 7'b1100111;
  localparam logic [6:0] op_lui    = 7'b0110111;
  localparam logic [6:0] op_auipc  = 7'b0010111;

  // ALU operation codes
  localparam logic [3:0] alu_add  = 4'b0000;
  localparam logic [3:0] alu_sub  = 4'b0001;
  localparam logic [3:0] alu_sll  = 4'b0010;
  localparam logic [3:0] alu_slt  = 4'b0100;
  localparam logic [3:0] alu_sltu = 4'b0110;
  localparam logic [3:0] alu_xor  = 4'b1000;
  localparam logic [3:0] alu_srl  = 4'b1010;
  localparam logic [3:0] alu_sra  = 4'b1011;
  localparam logic [3:0] alu_or   = 4'b1100;
  localparam logic [3:0] alu_and  = 4'b1110;

  // Datapath mux selects
  localparam logic       addr_pc     = 1'b0;
  localparam logic       addr_aluout = 1'b1;
  localparam logic       pcsrc_alu   = 1'b0;
  localparam logic       pcsrc_aluout = 1'b1;
  localparam logic [1:0] asel_rs1    = 2'd0;
  localparam logic [1:0] asel_pc     = 2'd1;
  localparam logic [1:0] asel_oldpc  = 2'd2;
  localparam logic [1:0] asel_zero   = 2'd3;
  localparam logic [1:0] bsel_rs2    = 2'd0;
  localparam logic [1:0] bsel_imm    = 2'd1;
  localparam logic [1:0] bsel_four   = 2'd2;
  localparam logic [2:0] imm_i       = 3'd0;
  localparam logic [2:0] imm_s       = 3'd1;
  localparam logic [2:0] imm_b       = 3'd2;
  localparam logic [2:0] imm_u       = 3'd3;
  localparam logic [2:0] imm_j       = 3'd4;
  localparam logic       wb_aluout   = 1'b0;
  localparam logic       wb_mem      = 1'b1;

  typedef enum logic [3:0] {
    st_fetch, st_decode, st_exec_r, st_exec_i, st_addr, st_mem_rd, st_mem_wr, st_wb_alu,
    st_wb_mem, st_branch, st_jal, st_jalr_a, st_jalr_b, st_lui, st_auipc, st_trap
  } state_t;

endpackage

// File: rtl/alu_dec.sv
// Purpose: ALU operation decode for OP, OP-IMM and BRANCH, plus branch-taken polarity.
// Latency: combinational.
// Backpressure: none.
// Ports: opcode/funct3/bit30 (instr fields) in; alu_sel (4-bit ALU code), br_on_nonzero out.
module alu_dec
  import rv32i_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       bit30,
  output logic [3:0] alu_sel,
  output logic       br_on_nonzero
);

  // bne, blt and bltu are taken when the compare result is non-zero; the
  // others when it is zero. That pattern is exactly funct3[2] ^ funct3[0].
  assign br_on_nonzero = funct3[2] ^ funct3[0];

  always_comb begin
    alu_sel = alu_add;
    case (opcode)
      op_r:   alu_sel = {funct3, bit30};
      // Only the shift-right pair uses bit30 as a selector for immediates;
      // elsewhere it is immediate data (addi must never turn into sub).
      op_imm: alu_sel = {funct3, (funct3 == 3'b101) & bit30};
      op_branch: begin
        case (funct3[2:1])
          2'b00:   alu_sel = alu_sub;
          2'b10:   alu_sel = alu_slt;
          2'b11:   alu_sel = alu_sltu;
          default: alu_sel = alu_add;
        endcase
      end
      default: alu_sel = alu_add;
    endcase
  end

endmodule

// File: rtl/control_multiciclo.sv
// Purpose: multicycle control FSM for RV32I (fetch/decode/execute/memory/writeback over a shared datapath).
// Latency: 3..5 cycles per instruction with mem_ready high; each memory access adds one cycle per mem_ready=0.
// Backpressure: mem_valid held with a stable address source until mem_ready; FSM stalls in FETCH/MEM_RD/MEM_WR.
// Ports: clk, nreset (sync, active-low), instr (IR), zero (ALU flag), mem_ready in;
//        mem_valid/mem_we/addr_sel, ir_we/oldpc_we/pc_we/pc_src, alu_a_sel/alu_b_sel/alu_sel/imm_sel,
//        rf_we/wb_sel, illegal (sticky until reset) out.
module control_multiciclo
  import rv32i_pkg::*;
#(
  parameter bit RESET_PC_WE = 1'b0
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_valid,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_we,
  output logic        oldpc_we,
  output logic        pc_we,
  output logic        pc_src,
  output logic [1:0]  alu_a_sel,
  output logic [1:0]  alu_b_sel,
  output logic [3:0]  alu_sel,
  output logic [2:0]  imm_sel,
  output logic        rf_we,
  output logic        wb_sel,
  output logic        illegal
);

  state_t     state;
  logic       boot_q;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [3:0] dec_sel;
  logic       br_on_nonzero;
  logic       taken;
  logic       unused_instr_bits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  alu_dec u_alu_dec (
    .opcode        (opcode),
    .funct3        (funct3),
    .bit30         (instr[30]),
    .alu_sel       (dec_sel),
    .br_on_nonzero (br_on_nonzero)
  );

  assign taken = br_on_nonzero ? !zero : zero;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state  <= st_fetch;
      // Optional first cycle after reset that only loads the reset vector.
      boot_q <= RESET_PC_WE;
    end else begin
      boot_q <= 1'b0;
      case (state)
        st_fetch:  if (!boot_q && mem_ready) state <= st_decode;
        st_decode: begin
          case (opcode)
            op_r:                state <= st_exec_r;
            op_imm:              state <= st_exec_i;
            op_load, op_store:   state <= st_addr;
            op_branch:           state <= st_branch;
            op_jal:              state <= st_jal;
            op_jalr:             state <= st_jalr_a;
            op_lui:              state <= st_lui;
            op_auipc:            state <= st_auipc;
            default:             state <= st_trap;
          endcase
        end
        st_exec_r, st_exec_i, st_jal, st_jalr_b, st_lui, st_auipc: state <= st_wb_alu;
        st_addr:   state <= (opcode == op_store) ? st_mem_wr : st_mem_rd;
        st_mem_rd: if (mem_ready) state <= st_wb_mem;
        st_mem_wr: if (mem_ready) state <= st_fetch;
        st_jalr_a: state <= st_jalr_b;
        st_wb_alu, st_wb_mem, st_branch: state <= st_fetch;
        st_trap:   state <= st_trap;
        default:   state <= st_trap;
      endcase
    end
  end

  always_comb begin
    mem_valid = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = addr_pc;
    ir_we     = 1'b0;
    oldpc_we  = 1'b0;
    pc_we     = 1'b0;
    pc_src    = pcsrc_alu;
    alu_a_sel = asel_rs1;
    alu_b_sel = bsel_rs2;
    alu_sel   = alu_add;
    imm_sel   = imm_i;
    rf_we     = 1'b0;
    wb_sel    = wb_aluout;
    illegal   = 1'b0;
    case (state)
      st_fetch: begin
        alu_a_sel = asel_pc;
        alu_b_sel = bsel_four;
        if (boot_q) begin
          pc_we = 1'b1;
        end else begin
          mem_valid = 1'b1;
          if (mem_ready) begin
            ir_we    = 1'b1;
            oldpc_we = 1'b1;
            pc_we    = 1'b1;
          end
        end
      end
      st_decode: begin
        // ALUOut speculatively captures the branch/jump target.
        alu_a_sel = asel_oldpc;
        alu_b_sel = bsel_imm;
        imm_sel   = (opcode == op_jal) ? imm_j : imm_b;
      end
      st_exec_r: alu_sel = dec_sel;
      st_exec_i: begin
        alu_b_sel = bsel_imm;
        alu_sel   = dec_sel;
      end
      st_addr: begin
        alu_b_sel = bsel_imm;
        imm_sel   = (opcode == op_store) ? imm_s : imm_i;
      end
      st_mem_rd: begin
        mem_valid = 1'b1;
        addr_sel  = addr_aluout;
      end
      st_mem_wr: begin
        mem_valid = 1'b1;
        mem_we    = 1'b1;
        addr_sel  = addr_aluout;
      end
      st_wb_alu: rf_we = 1'b1;
      st_wb_mem: begin
        rf_we  = 1'b1;
        wb_sel = wb_mem;
      end
      st_branch: begin
        alu_sel = dec_sel;
        pc_src  = pcsrc_aluout;
        pc_we   = taken;
      end
      st_jal, st_jalr_b: begin
        // Target already sits in ALUOut; the ALU forms the link value.
        pc_we     = 1'b1;
        pc_src    = pcsrc_aluout;
        alu_a_sel = asel_oldpc;
        alu_b_sel = bsel_four;
      end
      st_jalr_a: alu_b_sel = bsel_imm;
      st_lui: begin
        alu_a_sel = asel_zero;
        alu_b_sel = bsel_imm;
        imm_sel   = imm_u;
      end
      st_auipc: begin
        alu_a_sel = asel_oldpc;
        alu_b_sel = bsel_imm;
        imm_sel   = imm_u;
      end
      st_trap: illegal = 1'b1;
      default: illegal = 1'b1;
    endcase
    // Reset abandons any in-flight request and blocks all state updates.
    if (!nreset) begin
      mem_valid = 1'b0;
      mem_we    = 1'b0;
      ir_we     = 1'b0;
      oldpc_we  = 1'b0;
      pc_we     = 1'b0;
      rf_we     = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_multiciclo.sv
module tb_control_multiciclo;

  logic        clk = 1'b0;
  logic        nreset;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        mem_valid, mem_we, addr_sel, ir_we, oldpc_we, pc_we, pc_src;
  logic [1:0]  alu_a_sel, alu_b_sel;
  logic [3:0]  alu_sel;
  logic [2:0]  imm_sel;
  logic        rf_we, wb_sel, illegal;

  always #5 clk = ~clk;

  control_multiciclo #(.RESET_PC_WE(1'b0)) dut (
    .clk(clk), .nreset(nreset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .mem_valid(mem_valid), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we),
    .oldpc_we(oldpc_we), .pc_we(pc_we), .pc_src(pc_src), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .alu_sel(alu_sel), .imm_sel(imm_sel), .rf_we(rf_we),
    .wb_sel(wb_sel), .illegal(illegal)
  );

  int checks = 0;
  int errors = 0;
  logic [20:0] trace[$];
  int fetch_stalls = -1;   // -1: random stalls, else exact count
  int mem_stalls   = -1;
  int zero_force   = -1;   // -1: random zero flag, else fixed

  // Output vector layout:
  // [20]mem_valid [19]mem_we [18]addr_sel [17]ir_we [16]oldpc_we [15]pc_we [14]pc_src
  // [13:12]alu_a [11:10]alu_b [9:6]alu_sel [5:3]imm_sel [2]rf_we [1]wb_sel [0]illegal
  function automatic logic [20:0] pk(input logic mv, input logic mwe, input logic as,
                                     input logic irw, input logic opw, input logic pcw,
                                     input logic pcs, input logic [1:0] a, input logic [1:0] b,
                                     input logic [3:0] sel, input logic [2:0] imm,
                                     input logic rfw, input logic wbs, input logic ill);
    return {mv, mwe, as, irw, opw, pcw, pcs, a, b, sel, imm, rfw, wbs, ill};
  endfunction

  // Enables and illegal are always checked; selects only where they matter.
  function automatic logic [20:0] mk(input logic c_as, input logic c_pcs, input logic c_alu,
                                     input logic c_imm, input logic c_wb);
    return pk(1'b1, 1'b1, c_as, 1'b1, 1'b1, 1'b1, c_pcs, {2{c_alu}}, {2{c_alu}}, {4{c_alu}},
              {3{c_imm}}, 1'b1, c_wb, 1'b1);
  endfunction

  function automatic logic [20:0] dut_vec();
    return {mem_valid, mem_we, addr_sel, ir_we, oldpc_we, pc_we, pc_src, alu_a_sel, alu_b_sel,
            alu_sel, imm_sel, rf_we, wb_sel, illegal};
  endfunction

  // Inputs are set by the caller #1 after a rising edge; outputs are sampled on the falling edge.
  task automatic step(input string name, input logic [20:0] v, input logic [20:0] m);
    logic [20:0] act;
    @(negedge clk);
    act = dut_vec();
    trace.push_back(act);
    checks++;
    if ((act & m) !== (v & m)) begin
      errors++;
      $display("FAIL %s: got %h expected %h (mask %h) instr %h", name, act, v, m, instr);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pin(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic rnd_in();
    mem_ready = 1'($urandom_range(0, 1));
    zero = (zero_force < 0) ? 1'($urandom_range(0, 1)) : (zero_force != 0);
  endtask

  function automatic logic [20:0] idle(input logic ill);
    return pk(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd0, 3'd0, 0, 0, ill);
  endfunction

  task automatic wb_step(input logic from_mem);
    rnd_in();
    step("writeback", pk(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd0, 3'd0, 1, from_mem, 0),
         mk(0, 0, 0, 0, 1));
  endtask

  // Memory-side access: request held until the cycle mem_ready is seen.
  task automatic mem_access(input string name, input logic is_fetch, input logic we);
    int   n = 0;
    int   lim;
    logic mr;
    lim = is_fetch ? fetch_stalls : mem_stalls;
    do begin
      if (lim < 0) mr = (n >= 6) || ($urandom_range(0, 3) != 0);
      else         mr = (n >= lim);
      mem_ready = mr;
      zero = 1'($urandom_range(0, 1));
      if (is_fetch)
        step(name, pk(1, 0, 0, mr, mr, mr, 0, 2'd1, 2'd2, 4'd0, 3'd0, 0, 0, 0), mk(1, mr, 1, 0, 0));
      else
        step(name, pk(1, we, 1, 0, 0, 0, 0, 2'd0, 2'd0, 4'd0, 3'd0, 0, 0, 0), mk(1, 0, 0, 0, 0));
      n++;
    end while (!mr);
  endtask

  function automatic bit is_legal(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
  endfunction

  // Reference behaviour for one whole instruction, from fetch to its last cycle.
  task automatic run_instr(input logic [31:0] ins);
    logic [6:0] op;
    logic [2:0] f3;
    logic       b30, tk;
    logic [3:0] bsel;
    trace.delete();
    mem_access("fetch", 1'b1, 1'b0);
    instr = ins;
    op = ins[6:0];
    f3 = ins[14:12];
    b30 = ins[30];
    rnd_in();
    step("decode", pk(0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 4'd0, (op == 7'b1101111) ? 3'd4 : 3'd2, 0, 0, 0),
         mk(0, 0, 1, 1, 0));
    case (op)
      7'b0110011: begin
        rnd_in();
        step("exec_r", pk(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, {f3, b30}, 3'd0, 0, 0, 0), mk(0, 0, 1, 0, 0));
        wb_step(1'b0);
      end
      7'b0010011: begin
        rnd_in();
        step("exec_i", pk(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd1, {f3, (f3 == 3'b101) ? b30 : 1'b0}, 3'd0, 0, 0, 0),
             mk(0, 0, 1, 1, 0));
        wb_step(1'b0);
      end
      7'b0000011, 7'b0100011: begin
        rnd_in();
        step("addr", pk(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 4'd0, op[5] ? 3'd1 : 3'd0, 0, 0, 0),
             mk(0, 0, 1, 1, 0));
        mem_access(op[5] ? "mem_wr" : "mem_rd", 1'b0, op[5]);
        if (!op[5]) wb_step(1'b1);
      end
      7'b1100011: begin
        rnd_in();
        // Equality branches compare with sub (zero = equal); ordered ones use
        // slt/sltu (non-zero = less-than). Odd funct3 inverts the sense.
        if (f3[2]) begin
          bsel = f3[1] ? 4'b0110 : 4'b0100;
          tk = f3[0] ? zero : !zero;
        end else begin
          bsel = 4'b0001;
          tk = f3[0] ? !zero : zero;
        end
        step("branch", pk(0, 0, 0, 0, 0, tk, 1, 2'd0, 2'd0, bsel, 3'd0, 0, 0, 0), mk(0, tk, 1, 0, 0));
      end
      7'b1101111, 7'b1100111: begin
        if (op == 7'b1100111) begin
          rnd_in();
          step("jalr_a", pk(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 4'd0, 3'd0, 0, 0, 0), mk(0, 0, 1, 1, 0));
        end
        rnd_in();
        step("jump", pk(0, 0, 0, 0, 0, 1, 1, 2'd2, 2'd2, 4'd0, 3'd0, 0, 0, 0), mk(0, 1, 1, 0, 0));
        wb_step(1'b0);
      end
      7'b0110111, 7'b0010111: begin
        rnd_in();
        step("upper", pk(0, 0, 0, 0, 0, 0, 0, op[5] ? 2'd3 : 2'd2, 2'd1, 4'd0, 3'd3, 0, 0, 0),
             mk(0, 0, 1, 1, 0));
        wb_step(1'b0);
      end
      default: begin
        repeat (10) begin
          rnd_in();
          step("trap", idle(1'b1), mk(0, 0, 0, 0, 0));
        end
        nreset = 1'b0;
        rnd_in();
        step("trap_reset", idle(1'b1), mk(0, 0, 0, 0, 0));
        nreset = 1'b1;
      end
    endcase
  endtask

  task automatic fetch_reset();
    trace.delete();
    mem_ready = 1'b0;
    zero = 1'($urandom_range(0, 1));
    step("fetch_wait", pk(1, 0, 0, 0, 0, 0, 0, 2'd1, 2'd2, 4'd0, 3'd0, 0, 0, 0), mk(1, 0, 1, 0, 0));
    nreset = 1'b0;
    step("fetch_reset", idle(1'b0), mk(0, 0, 0, 0, 0));
    nreset = 1'b1;
  endtask

  initial begin
    logic [31:0] ins;
    logic [20:0] t;
    int          k;
    nreset = 1'b0;
    mem_ready = 1'b0;
    zero = 1'b0;
    instr = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    step("reset", idle(1'b0), mk(0, 0, 0, 0, 0));
    t = trace[0];
    pin("reset_mem_valid", 32'(t[20]), 32'd0);
    pin("reset_illegal", 32'(t[0]), 32'd0);
    nreset = 1'b1;

    fetch_stalls = 0;
    mem_stalls = 0;

    run_instr(32'h402081B3);  // sub x3,x1,x2
    pin("sub_len", 32'(trace.size()), 32'd4);
    t = trace[2]; pin("sub_exec_sel", 32'(t[9:6]), 32'b0001);
    t = trace[3]; pin("sub_wb", 32'({t[2], t[1]}), 32'b10);
    t = trace[0]; pin("sub_ir_we_c1", 32'(t[17]), 32'd1);
    for (int i = 1; i < 4; i++) begin
      t = trace[i];
      pin("sub_ir_we_later", 32'(t[17]), 32'd0);
    end

    run_instr(32'hC0000093);  // addi x1,x0,-1024
    t = trace[2]; pin("addi_sel", 32'(t[9:6]), 32'b0000);
    run_instr(32'h4040D093);  // srai x1,x1,4
    t = trace[2]; pin("srai_sel", 32'(t[9:6]), 32'b1011);

    mem_stalls = 3;
    run_instr(32'h0080A283);  // lw x5,8(x1)
    pin("lw_len", 32'(trace.size()), 32'd8);
    for (int i = 3; i < 7; i++) begin
      t = trace[i];
      pin("lw_mem_hold", 32'({t[20], t[18]}), 32'b11);
    end
    t = trace[7]; pin("lw_wb_mem", 32'({t[2], t[1]}), 32'b11);
    mem_stalls = 0;

    zero_force = 1;
    run_instr(32'h00209863);  // bne x1,x2,+16 with equal operands
    t = trace[2]; pin("bne_sel", 32'(t[9:6]), 32'b0001);
    pin("bne_not_taken", 32'(t[15]), 32'd0);
    zero_force = 0;
    run_instr(32'h00209863);
    t = trace[2]; pin("bne_taken", 32'({t[15], t[14]}), 32'b11);
    run_instr(32'h0020C863);  // blt
    t = trace[2]; pin("blt_sel", 32'(t[9:6]), 32'b0100);
    run_instr(32'h0020F863);  // bgeu
    t = trace[2]; pin("bgeu_sel", 32'(t[9:6]), 32'b0110);
    zero_force = -1;

    run_instr(32'h00000000);  // illegal
    t = trace[11]; pin("trap_sticky", 32'(t[0]), 32'd1);
    mem_ready = 1'b1;
    zero = 1'b0;
    #1;
    pin("after_trap_reset_illegal", 32'(illegal), 32'd0);
    pin("after_trap_reset_fetch", 32'(mem_valid), 32'd1);

    fetch_reset();
    t = trace[1];
    pin("fetch_reset_en", 32'({t[20], t[17], t[15]}), 32'd0);

    fetch_stalls = -1;
    mem_stalls = -1;
    for (int n = 0; n < 250; n++) begin
      k = $urandom_range(0, 19);
      ins = $urandom;
      case (k)
        0, 1, 19: ins[6:0] = 7'b0110011;
        2, 3:     ins[6:0] = 7'b0010011;
        4, 5:     ins[6:0] = 7'b0000011;
        6, 7:     ins[6:0] = 7'b0100011;
        8, 9, 10: begin
          ins[6:0] = 7'b1100011;
          case ($urandom_range(0, 5))
            0: ins[14:12] = 3'b000;
            1: ins[14:12] = 3'b001;
            2: ins[14:12] = 3'b100;
            3: ins[14:12] = 3'b101;
            4: ins[14:12] = 3'b110;
            default: ins[14:12] = 3'b111;
          endcase
        end
        11, 12:   ins[6:0] = 7'b1101111;
        13, 14:   ins[6:0] = 7'b1100111;
        15:       ins[6:0] = 7'b0110111;
        16:       ins[6:0] = 7'b0010111;
        default: begin
          if (is_legal(ins[6:0])) ins[6:0] = 7'b1111111;
        end
      endcase
      if (k == 17) fetch_reset();
      else run_instr(ins);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_multiciclo.md
Name: control_multiciclo

Overview:
- Multicycle control FSM for the RV32I core.
- Sequences fetch, decode, execute, memory and writeback over the shared datapath: one ALU, PC register, IR, ALUOut register and register file.
- Drives the ALU 4-bit `sel` code and all datapath mux selects and write enables.
- Talks to a single unified instruction/data memory port through a valid/ready handshake.

Parameters:
- RESET_PC_WE, 0, when 1, asserts pc_we for one cycle after reset release so the datapath loads its reset vector.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- nreset  input  1  synchronous active-low reset.
- instr  input  32  contents of the IR register (stable after the IR write).
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes the current access this cycle.
- mem_valid  output  1  memory access request.
- mem_we  output  1  request is a write.
- addr_sel  output  1  memory address source: 0=PC, 1=ALUOut.
- ir_we  output  1  IR load enable.
- oldpc_we  output  1  old-PC register load enable (loaded together with IR).
- pc_we  output  1  PC load enable.
- pc_src  output  1  PC source: 0=ALU Y, 1=ALUOut.
- alu_a_sel  output  2  ALU a source: 0=rs1, 1=PC, 2=oldPC, 3=zero.
- alu_b_sel  output  2  ALU b source: 0=rs2, 1=imm, 2=constant 4.
- alu_sel  output  4  ALU operation code.
- imm_sel  output  3  immediate format: 0=I, 1=S, 2=B, 3=U, 4=J.
- rf_we  output  1  register file write enable.
- wb_sel  output  1  writeback source: 0=ALUOut, 1=memory read data.
- illegal  output  1  sticky illegal-opcode flag.

Behaviour:
- ALU codes:
  - 0000 add, 0001 sub, 0010 sll, 0100 slt, 0110 sltu, 1000 xor, 1010 srl, 1011 sra, 1100 or, 1110 and.
  - OP/OP-IMM: alu_sel = {funct3, alt}.
  - alt = instr[30] for OP; for OP-IMM, alt = instr[30] only when funct3=101, else alt = 0 (addi never becomes sub).
- Output style:
  - Outputs decode combinationally from state and instr.
  - Every enable not listed for a state is 0; select outputs not listed are don't-care but must be driven.
- States:
  - FETCH: mem_valid=1, addr_sel=0, alu a=PC, b=4, add. While mem_ready=0, stay with no enables. When mem_ready=1: ir_we=1, oldpc_we=1, pc_we=1, pc_src=0, go to DECODE.
  - DECODE: alu a=oldPC, b=imm (B or J format), add; ALUOut captures the branch/jump target. Next state by opcode:
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 0000011 / 0100011 → ADDR
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR_A
    - 0110111 → LUI
    - 0010111 → AUIPC
    - anything else → TRAP
  - EXEC_R: a=rs1, b=rs2, sel per decode → WB_ALU.
  - EXEC_I: a=rs1, b=imm(I), sel per decode → WB_ALU.
  - ADDR: a=rs1, b=imm (I for loads, S for stores), add → MEM_RD or MEM_WR.
  - MEM_RD: mem_valid=1, addr_sel=1; hold until mem_ready, then → WB_MEM.
  - MEM_WR: mem_valid=1, mem_we=1, addr_sel=1; hold until mem_ready, then → FETCH.
  - WB_ALU: rf_we=1, wb_sel=0 → FETCH.
  - WB_MEM: rf_we=1, wb_sel=1 → FETCH.
  - BRANCH: a=rs1, b=rs2 → FETCH. Compare op and taken condition by funct3:
    - beq/bne: sub; taken = zero / !zero.
    - blt/bge: slt; taken = !zero / zero.
    - bltu/bgeu: sltu; taken = !zero / zero.
    - When taken: pc_we=1, pc_src=1.
  - JAL: pc_we=1, pc_src=1; alu a=oldPC, b=4, add (ALUOut ← link) → WB_ALU.
  - JALR_A: a=rs1, b=imm(I), add → JALR_B.
  - JALR_B: pc_we=1, pc_src=1; a=oldPC, b=4, add → WB_ALU.
  - LUI: a=zero, b=imm(U), add → WB_ALU.
  - AUIPC: a=oldPC, b=imm(U), add → WB_ALU.
  - TRAP: illegal=1, all enables 0, mem_valid=0; stays in TRAP until reset.
- Latency with mem_ready tied to 1: R/I/LUI/AUIPC 4 cycles, load 5, store 4, branch 3, JAL 4, JALR 5.
- Reset:
  - nreset=0 at a rising edge → state FETCH, illegal=0.
  - While nreset=0, all enables and mem_valid are forced to 0; an in-flight memory request is abandoned.
- mem_valid stays asserted, with a stable address source, from request until the cycle mem_ready=1.

Decomposition:
- rv32i_pkg: opcode constants, ALU sel codes, state encoding, mux select encodings (alu_a_sel, alu_b_sel, imm_sel, wb_sel).
- Sub-module alu_dec (combinational): opcode, funct3, instr[30] → alu_sel, branch-taken polarity.

Test Plan:
- sub x3,x1,x2 (0x402081B3), mem_ready=1 → EXEC_R alu_sel=0001 in cycle 3; rf_we=1, wb_sel=0 in cycle 4; ir_we only in cycle 1.
- addi x1,x0,-1024 (0xC0000093, instr[30]=1) → alu_sel=0000. srai x1,x1,4 (0x4040D093) → alu_sel=1011.
- lw x5,8(x1), mem_ready low for 3 cycles in MEM_RD → mem_valid=1, addr_sel=1 held 4 cycles; rf_we=1, wb_sel=1 in the following cycle.
- bne x1,x2,+16 → BRANCH alu_sel=0001. zero=1: pc_we=0. zero=0: pc_we=1, pc_src=1. blt uses alu_sel=0100, bgeu uses 0110.
- instr=0x00000000 → TRAP; illegal=1 sticky for 10 cycles with all enables 0; nreset=0 one cycle → illegal=0, state FETCH.
- nreset driven low while FETCH waits on mem_ready=0 → next cycle mem_valid=0, ir_we=0, pc_we=0.
